// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_rx_statetype;

    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_BYTE_BITS  = 8;

endpackage

// File: rtl/sync_ff.sv
// Parameterized-depth single-bit synchronizer with synchronous active-low reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver: captures a character/digit byte pair and pulses
// new_SPI when a correctly sized frame closes, or frame_err otherwise.
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = SPI_FRAME_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sck,
    input  logic                     sdi,
    input  logic                     cs,
    output logic [SPI_BYTE_BITS-1:0] letter,
    output logic [SPI_BYTE_BITS-1:0] number,
    output logic                     new_SPI,
    output logic                     frame_err
);

    localparam int SR_BITS = 2 * SPI_BYTE_BITS;
    localparam int CW      = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] COUNT_MAX = CW'(FRAME_BITS + 1);
    localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_BITS);

    spi_rx_statetype state, state_next;

    logic sck_s, sdi_s, cs_s;
    logic sck_d, cs_d;
    logic sck_rise, cs_rise, cs_fall;

    logic [SR_BITS-1:0] shift_reg, shift_next;
    logic [CW-1:0]      bit_count, count_next;
    logic               load_frame, flag_err;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .reset(reset), .d(sck), .q(sck_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdi (.clk(clk), .reset(reset), .d(sdi), .q(sdi_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk(clk), .reset(reset), .d(cs),  .q(cs_s));

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_rise) state_next = SHIFT;
            SHIFT:   if (cs_fall) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The length check looks at count_next so a bit shifted in the same
    // cycle that chip-select releases still counts toward the frame.
    always_comb begin
        shift_next = shift_reg;
        count_next = bit_count;
        load_frame = 1'b0;
        flag_err   = 1'b0;
        case (state)
            IDLE: begin
                shift_next = '0;
                count_next = '0;
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_next = {shift_reg[SR_BITS-2:0], sdi_s};
                    if (bit_count != COUNT_MAX) begin
                        count_next = bit_count + 1'b1;
                    end
                end
                if (cs_fall) begin
                    if (count_next == FRAME_LEN) begin
                        load_frame = 1'b1;
                    end else begin
                        flag_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_count <= '0;
            letter    <= '0;
            number    <= '0;
            new_SPI   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            bit_count <= count_next;
            new_SPI   <= load_frame;
            frame_err <= flag_err;
            if (load_frame) begin
                letter <= shift_next[SR_BITS-1:SPI_BYTE_BITS];
                number <= shift_next[SPI_BYTE_BITS-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: bit-level SPI frames against a
// frame-level reference model plus a minimal downstream LCD controller model.
module tb_spi_frame_rx;

    logic       clk;
    logic       reset;
    logic       sck;
    logic       sdi;
    logic       cs;
    logic [7:0] letter;
    logic [7:0] number;
    logic       new_SPI;
    logic       frame_err;

    int compareCount  = 0;
    int mismatchCount = 0;

    int newTotal  = 0;
    int errTotal  = 0;
    int lcdEvents = 0;

    logic [7:0] prevLetter = 8'h00;
    logic [7:0] prevNumber = 8'h00;
    logic       prevReset  = 1'b0;

    logic [7:0] lcdLetter = 8'h00;
    logic [7:0] lcdNumber = 8'h00;

    logic [7:0] expLetter = 8'h00;
    logic [7:0] expNumber = 8'h00;

    spi_frame_rx #(
        .SYNC_STAGES(2),
        .FRAME_BITS (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .sdi      (sdi),
        .cs       (cs),
        .letter   (letter),
        .number   (number),
        .new_SPI  (new_SPI),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse counting, mutual exclusion and output hold, observed away from the active edge.
    always @(negedge clk) begin
        if (new_SPI)   newTotal++;
        if (frame_err) errTotal++;
        if (reset && prevReset) begin
            checkOutput("exclusive", {31'b0, new_SPI & frame_err}, 32'h0);
            if (!new_SPI) begin
                checkOutput("letterHold", {24'b0, letter}, {24'b0, prevLetter});
                checkOutput("numberHold", {24'b0, number}, {24'b0, prevNumber});
            end
        end
        prevLetter = letter;
        prevNumber = number;
        prevReset  = reset;
    end

    // Downstream controller: leaves its wait state the cycle after new_SPI and latches the bytes.
    always @(posedge clk) begin
        if (new_SPI) begin
            lcdLetter <= letter;
            lcdNumber <= number;
            lcdEvents <= lcdEvents + 1;
        end
    end

    task automatic applyStimulus(input int nbits, input logic [31:0] bits,
                                 input bit sameCycle, input bit resetMid);
        cs = 1'b1;
        waitCycles(4);
        for (int i = 0; i < nbits; i++) begin
            if (resetMid && i == 8) reset = 1'b0;
            sdi = bits[nbits-1-i];
            waitCycles(4);
            sck = 1'b1;
            if (sameCycle && i == nbits - 1) cs = 1'b0;
            waitCycles(4);
            sck = 1'b0;
        end
        if (!(sameCycle && nbits > 0)) begin
            waitCycles(4);
            cs = 1'b0;
        end
        waitCycles(10);
        if (resetMid) reset = 1'b1;
        waitCycles(4);
    endtask

    task automatic runFrame(input string name, input int nbits, input logic [31:0] bits,
                            input bit sameCycle, input bit resetMid);
        int newBefore, errBefore, lcdBefore;
        int expNew, expErr;
        newBefore = newTotal;
        errBefore = errTotal;
        lcdBefore = lcdEvents;
        applyStimulus(nbits, bits, sameCycle, resetMid);
        if (resetMid) begin
            expLetter = 8'h00;
            expNumber = 8'h00;
            expNew = 0;
            expErr = 0;
        end else if (nbits == 16) begin
            expLetter = bits[15:8];
            expNumber = bits[7:0];
            expNew = 1;
            expErr = 0;
        end else begin
            expNew = 0;
            expErr = 1;
        end
        checkOutput({name, ".newPulses"}, newTotal - newBefore, expNew);
        checkOutput({name, ".errPulses"}, errTotal - errBefore, expErr);
        checkOutput({name, ".letter"}, {24'b0, letter}, {24'b0, expLetter});
        checkOutput({name, ".number"}, {24'b0, number}, {24'b0, expNumber});
        if (!resetMid) begin
            checkOutput({name, ".lcdEvents"}, lcdEvents - lcdBefore, expNew);
            if (expNew == 1) begin
                checkOutput({name, ".lcdLetter"}, {24'b0, lcdLetter}, {24'b0, expLetter});
                checkOutput({name, ".lcdNumber"}, {24'b0, lcdNumber}, {24'b0, expNumber});
            end
        end
    endtask

    initial begin
        int lenSel;
        int nbits;
        logic [31:0] bits;
        reset = 1'b0;
        sck   = 1'b0;
        sdi   = 1'b0;
        cs    = 1'b0;
        waitCycles(5);
        checkOutput("reset.letter",    {24'b0, letter},    32'h0);
        checkOutput("reset.number",    {24'b0, number},    32'h0);
        checkOutput("reset.new_SPI",   {31'b0, new_SPI},   32'h0);
        checkOutput("reset.frame_err", {31'b0, frame_err}, 32'h0);
        reset = 1'b1;
        waitCycles(3);

        runFrame("valid4137", 16, 32'h4137, 1'b0, 1'b0);
        runFrame("short15",   15, $urandom, 1'b0, 1'b0);
        runFrame("long17",    17, $urandom, 1'b0, 1'b0);
        runFrame("b2bA",      16, 32'h4831, 1'b0, 1'b0);
        runFrame("b2bB",      16, 32'h5A39, 1'b0, 1'b0);
        runFrame("resetMid",  16, $urandom, 1'b0, 1'b1);
        runFrame("afterRst",  16, 32'h4232, 1'b0, 1'b0);
        runFrame("sameCycle", 16, 32'h5533, 1'b1, 1'b0);
        runFrame("zeroEdges", 0,  32'h0,    1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            lenSel = $urandom_range(0, 4);
            case (lenSel)
                0: nbits = 15;
                1: nbits = 17;
                2: nbits = $urandom_range(0, 20);
                default: nbits = 16;
            endcase
            bits = $urandom;
            runFrame("random", nbits, bits, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
